tmr_bus_voter: RTL and testbench
================================

Name: tmr_bus_voter

Overview:
- Sits directly upstream of the bus monitor in the triple-redundant RISC-V system.
- Compares the bus requests issued by the three lock-stepped CPUs and forwards one bitwise-majority request to the shared memory bus.
- Drives the monitor's bus_invalid[2:0] and cpu_back_online inputs.
- Tracks each CPU through fault, reset and resynchronisation, so that a CPU recovered by the monitor rejoins the vote only after proving lock-step.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, write data width. Strobe width is DATA_W/8.
- SKEW_TOL, 2, number of consecutive mismatching request cycles before a CPU is declared faulted. Range 1..15.
- RESYNC_CYCLES, 8, number of consecutive matching request cycles before a resyncing CPU rejoins. Range 1..255.

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_areset  in  1  synchronous, active-high reset.
- cpuN_req (N=0..2)  in  1  CPU N request valid.
- cpuN_we  in  1  write enable.
- cpuN_addr  in  ADDR_W  address.
- cpuN_wdata  in  DATA_W  write data.
- cpuN_wstrb  in  DATA_W/8  byte strobes.
- actual_cpu_reset  in  3  per-CPU reset currently asserted.
- ack_back_online  in  1  monitor acknowledge of cpu_back_online.
- voted_req  out  1  voted request valid.
- voted_we, voted_addr, voted_wdata, voted_wstrb  out  as above  voted request fields.
- voted_ready  in  1  downstream accepts the voted request.
- cpu_ack  out  3  per-CPU request accepted.
- bus_invalid  out  3  level; CPU N faulted.
- cpu_back_online  out  1  level; a CPU has rejoined.
- no_majority  out  1  level; fewer than two voting CPUs agree.

Behaviour:
- Compare word per CPU: {req, we, addr, wdata, wstrb}, width 2+ADDR_W+DATA_W+DATA_W/8. Compare and vote logic is combinational.
- Per-CPU state: ACTIVE, FAULTED, EXCLUDED, RESYNC. All three CPUs are ACTIVE after reset.
- Only ACTIVE CPUs vote.
  - 3 voters: bitwise majority word. CPU i mismatches when its word differs from the majority.
  - 2 voters: if the words are equal, that word is the result. If they differ, both mismatch, no_majority=1, voted_req=0.
  - Fewer than 2 voters: no_majority=1, voted_req=0.
- Request cycle: a cycle in which the voted or any voting CPU's req is 1. Mismatch and match counters advance only on request cycles. Idle cycles hold the counters.
- ACTIVE:
  - A mismatch increments mis_cnt[i]; a match clears it.
  - When mis_cnt reaches SKEW_TOL, the CPU goes to FAULTED on the next edge and mis_cnt is cleared.
- FAULTED: bus_invalid[i]=1 from the first cycle in FAULTED. The CPU leaves FAULTED only via actual_cpu_reset[i].
- actual_cpu_reset[i]=1 forces EXCLUDED from any state. This has priority over all other transitions. EXCLUDED sets bus_invalid[i]=0.
- EXCLUDED -> RESYNC on the first cycle actual_cpu_reset[i]=0. This clears match_cnt[i].
- RESYNC:
  - CPU i is compared against the result of the voters without voting itself.
  - A match increments match_cnt[i]; a mismatch clears it. A mismatch in RESYNC is not a fault.
  - If there is no majority, match_cnt holds.
  - When match_cnt reaches RESYNC_CYCLES, the CPU goes to ACTIVE and sets back_pending.
- cpu_back_online = back_pending, a registered level.
  - Cleared on a cycle where ack_back_online=1.
  - If a set and an ack occur in the same cycle, the set wins.
- Handshake:
  - voted_req holds with stable fields until voted_ready.
  - cpu_ack[i] = voted_req & voted_ready for CPUs in ACTIVE or RESYNC; 0 otherwise.
  - A stalled cycle (voted_req=1, voted_ready=0) still counts as a request cycle. CPUs hold their requests during the stall, so a match is expected.
- Reset values: voted_req=0, voted fields 0, cpu_ack=0, bus_invalid=0, cpu_back_online=0, no_majority=0. All counters are 0.
- Reset mid-transaction: the request is dropped. Downstream must tolerate voted_req falling without voted_ready.
- Latency: the voted outputs are registered, giving one cycle from CPU request to voted_req. bus_invalid and cpu_back_online are registered state outputs.
- Simultaneous faults with 3 voters: two differing CPUs each mismatch the majority independently. Both can reach FAULTED, leaving 1 voter, which sets no_majority.

Decomposition:
- Shared package tmr_voter_pkg holds:
  - cpu_state_t enum {ACTIVE, FAULTED, EXCLUDED, RESYNC};
  - the NUM_CPUS=3 constant;
  - the CMP_W function computing the compare-word width;
  - the counter widths.
- Sub-module tmr_cpu_tracker, instantiated three times:
  - Inputs: actual_cpu_reset, is_request_cycle, match, majority_ok.
  - Outputs: state, voting, fault_level, rejoin_pulse.
  - Contains the per-CPU FSM, mis_cnt and match_cnt.

Test Plan:
- Three identical writes, addr 0x8000_0010, data 0xDEADBEEF, voted_ready=1 -> voted_req one cycle later with the same fields; cpu_ack=3'b111; bus_invalid=0.
- CPU1 addr differs (0x8000_0014) for 1 request cycle, SKEW_TOL=2 -> no fault; the voted addr is 0x8000_0010. Differing for 2 consecutive request cycles -> bus_invalid=3'b010 on the next cycle, and it stays set.
- Faulted CPU1: actual_cpu_reset[1] pulsed 3 cycles, then 8 matching requests -> bus_invalid[1]=0 during reset; cpu_back_online=1 after the 8th match; cleared the cycle after ack_back_online. A mismatch at the 5th match restarts the count.
- CPU1 faulted, then CPU0 and CPU2 differ in wdata -> no_majority=1, voted_req=0, both mismatch; after 2 cycles bus_invalid=3'b111.
- voted_ready held 0 for 5 cycles with stable identical requests -> voted_req stays 1 with constant fields, no faults; cpu_ack pulses only in the accept cycle.
- s00_axi_areset asserted during a stalled request with CPU2 in RESYNC -> all outputs 0 next cycle; all CPUs ACTIVE afterwards.

Source files
------------

// File: rtl/tmr_voter_pkg.sv
// tmr_voter_pkg: shared CPU state type, CPU count, compare-word width helper and counter widths
package tmr_voter_pkg;
  typedef enum logic [1:0] {ACTIVE, FAULTED, EXCLUDED, RESYNC} cpu_state_t;
  localparam int NUM_CPUS = 3;
  localparam int MIS_W = 4;
  localparam int MATCH_W = 8;
  function automatic int CMP_W(input int addr_w, input int data_w);
    return 2 + addr_w + data_w + data_w / 8;
  endfunction
endpackage

// File: rtl/tmr_cpu_tracker.sv
// tmr_cpu_tracker: per-CPU ACTIVE/FAULTED/EXCLUDED/RESYNC tracker; in: reset, request cycle, match, majority; out: state, voting, fault, rejoin
module tmr_cpu_tracker
  import tmr_voter_pkg::*;
#(
  parameter int SKEW_TOL = 2,
  parameter int RESYNC_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cpu_reset,
  input  logic       i_req_cycle,
  input  logic       i_match,
  input  logic       i_majority_ok,
  output cpu_state_t o_state,
  output logic       o_voting,
  output logic       o_fault_level,
  output logic       o_rejoin_pulse
);
  cpu_state_t r_state;
  logic [MIS_W-1:0] r_mis_cnt;
  logic [MATCH_W-1:0] r_match_cnt;
  logic w_fault;
  logic w_step;
  assign w_fault = r_state == ACTIVE && i_req_cycle && !i_match && r_mis_cnt == MIS_W'(SKEW_TOL - 1);
  assign w_step = r_state == RESYNC && i_req_cycle && i_majority_ok;
  assign o_rejoin_pulse = w_step && i_match && r_match_cnt == MATCH_W'(RESYNC_CYCLES - 1);
  assign o_state = r_state;
  assign o_voting = r_state == ACTIVE;
  assign o_fault_level = r_state == FAULTED;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ACTIVE;
      r_mis_cnt <= '0;
      r_match_cnt <= '0;
    end else begin
      r_state <= i_cpu_reset ? EXCLUDED : w_fault ? FAULTED : o_rejoin_pulse ? ACTIVE :
                 r_state == EXCLUDED ? RESYNC : r_state;
      r_mis_cnt <= (i_cpu_reset || r_state != ACTIVE || w_fault) ? '0 :
                   !i_req_cycle ? r_mis_cnt : i_match ? '0 : r_mis_cnt + 1'b1;
      r_match_cnt <= (i_cpu_reset || r_state != RESYNC || o_rejoin_pulse) ? '0 :
                     !w_step ? r_match_cnt : i_match ? r_match_cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/tmr_bus_voter.sv
// tmr_bus_voter: majority-votes three CPU bus requests onto one registered request; drives bus_invalid, cpu_back_online, no_majority, cpu_ack
module tmr_bus_voter
  import tmr_voter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SKEW_TOL = 2,
  parameter int RESYNC_CYCLES = 8
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_areset,
  input  logic                cpu0_req,
  input  logic                cpu0_we,
  input  logic [ADDR_W-1:0]   cpu0_addr,
  input  logic [DATA_W-1:0]   cpu0_wdata,
  input  logic [DATA_W/8-1:0] cpu0_wstrb,
  input  logic                cpu1_req,
  input  logic                cpu1_we,
  input  logic [ADDR_W-1:0]   cpu1_addr,
  input  logic [DATA_W-1:0]   cpu1_wdata,
  input  logic [DATA_W/8-1:0] cpu1_wstrb,
  input  logic                cpu2_req,
  input  logic                cpu2_we,
  input  logic [ADDR_W-1:0]   cpu2_addr,
  input  logic [DATA_W-1:0]   cpu2_wdata,
  input  logic [DATA_W/8-1:0] cpu2_wstrb,
  input  logic [2:0]          actual_cpu_reset,
  input  logic                ack_back_online,
  output logic                voted_req,
  output logic                voted_we,
  output logic [ADDR_W-1:0]   voted_addr,
  output logic [DATA_W-1:0]   voted_wdata,
  output logic [DATA_W/8-1:0] voted_wstrb,
  input  logic                voted_ready,
  output logic [2:0]          cpu_ack,
  output logic [2:0]          bus_invalid,
  output logic                cpu_back_online,
  output logic                no_majority
);
  localparam int W = CMP_W(ADDR_W, DATA_W);
  logic [W-1:0] w_word [NUM_CPUS];
  logic [W-1:0] w_maj, w_a, w_b, w_result, r_voted;
  logic [NUM_CPUS-1:0] w_vote, w_match, w_rejoin, w_req;
  cpu_state_t w_state [NUM_CPUS];
  logic [1:0] w_nvote;
  logic w_majority_ok, w_req_cycle, r_no_majority, r_back_pending;
  assign w_word[0] = {cpu0_req, cpu0_we, cpu0_addr, cpu0_wdata, cpu0_wstrb};
  assign w_word[1] = {cpu1_req, cpu1_we, cpu1_addr, cpu1_wdata, cpu1_wstrb};
  assign w_word[2] = {cpu2_req, cpu2_we, cpu2_addr, cpu2_wdata, cpu2_wstrb};
  assign w_maj = (w_word[0] & w_word[1]) | (w_word[0] & w_word[2]) | (w_word[1] & w_word[2]);
  // With exactly two voters, w_a/w_b select that pair whichever CPU is missing
  assign w_a = w_vote[0] ? w_word[0] : w_word[1];
  assign w_b = w_vote[2] ? w_word[2] : w_word[1];
  assign w_nvote = 2'(w_vote[0]) + 2'(w_vote[1]) + 2'(w_vote[2]);
  assign w_result = w_nvote == 2'd3 ? w_maj : w_a;
  assign w_majority_ok = w_nvote == 2'd3 || (w_nvote == 2'd2 && w_a == w_b);
  assign w_req_cycle = r_voted[W-1] || |(w_req & w_vote);
  for (genvar i = 0; i < NUM_CPUS; i++) begin : g_cpu
    assign w_req[i] = w_word[i][W-1];
    // A lone voter has nothing to disagree with, so it is never charged a mismatch
    assign w_match[i] = w_majority_ok ? w_word[i] == w_result : w_nvote < 2'd2;
    assign cpu_ack[i] = voted_req && voted_ready && (w_state[i] == ACTIVE || w_state[i] == RESYNC);
    tmr_cpu_tracker #(.SKEW_TOL(SKEW_TOL), .RESYNC_CYCLES(RESYNC_CYCLES)) u_trk (
      .clk(s00_axi_aclk),
      .rst(s00_axi_areset),
      .i_cpu_reset(actual_cpu_reset[i]),
      .i_req_cycle(w_req_cycle),
      .i_match(w_match[i]),
      .i_majority_ok(w_majority_ok),
      .o_state(w_state[i]),
      .o_voting(w_vote[i]),
      .o_fault_level(bus_invalid[i]),
      .o_rejoin_pulse(w_rejoin[i])
    );
  end
  assign {voted_req, voted_we, voted_addr, voted_wdata, voted_wstrb} = r_voted;
  assign cpu_back_online = r_back_pending;
  assign no_majority = r_no_majority;
  always_ff @(posedge s00_axi_aclk)
    if (s00_axi_areset) begin
      r_voted <= '0;
      r_no_majority <= 1'b0;
      r_back_pending <= 1'b0;
    end else begin
      if (!r_voted[W-1] || voted_ready) r_voted <= {w_majority_ok && w_result[W-1], w_result[W-2:0]};
      r_no_majority <= !w_majority_ok;
      r_back_pending <= |w_rejoin || (r_back_pending && !ack_back_online);
    end
endmodule

// File: tb/tb_tmr_bus_voter.sv
// tb_tmr_bus_voter: scoreboard bench for tmr_bus_voter covering vote, fault, resync, stall and reset
module tb_tmr_bus_voter;
  localparam logic [31:0] A0 = 32'h8000_0010, A1 = 32'h8000_0014, A2 = 32'h8000_0020;
  localparam logic [31:0] A3 = 32'h8000_0030, A4 = 32'h8000_0040, A5 = 32'h8000_0050;
  localparam logic [31:0] D0 = 32'hDEAD_BEEF, D1 = 32'hCAFE_F00D, D2 = 32'h1234_5678, D3 = 32'h0BAD_0BAD;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} exp_t;
  logic clk = 1'b0, areset = 1'b1, ready = 1'b1, ack_bo = 1'b0;
  logic [2:0] cpu_rst = 3'b000;
  logic cpu_req [3];
  logic cpu_we [3];
  logic [31:0] cpu_addr [3];
  logic [31:0] cpu_wdata [3];
  logic [3:0] cpu_wstrb [3];
  logic voted_req, voted_we, back_online, no_majority;
  logic [31:0] voted_addr, voted_wdata;
  logic [3:0] voted_wstrb;
  logic [2:0] cpu_ack, bus_invalid;
  int n_checks = 0, n_fail = 0;
  exp_t sb_q[$];
  exp_t sb_e;
  tmr_bus_voter dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .cpu0_req(cpu_req[0]), .cpu0_we(cpu_we[0]), .cpu0_addr(cpu_addr[0]), .cpu0_wdata(cpu_wdata[0]), .cpu0_wstrb(cpu_wstrb[0]),
    .cpu1_req(cpu_req[1]), .cpu1_we(cpu_we[1]), .cpu1_addr(cpu_addr[1]), .cpu1_wdata(cpu_wdata[1]), .cpu1_wstrb(cpu_wstrb[1]),
    .cpu2_req(cpu_req[2]), .cpu2_we(cpu_we[2]), .cpu2_addr(cpu_addr[2]), .cpu2_wdata(cpu_wdata[2]), .cpu2_wstrb(cpu_wstrb[2]),
    .actual_cpu_reset(cpu_rst), .ack_back_online(ack_bo),
    .voted_req(voted_req), .voted_we(voted_we), .voted_addr(voted_addr), .voted_wdata(voted_wdata),
    .voted_wstrb(voted_wstrb), .voted_ready(ready), .cpu_ack(cpu_ack), .bus_invalid(bus_invalid),
    .cpu_back_online(back_online), .no_majority(no_majority)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_all(input logic req, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < 3; i++) begin
      cpu_req[i] = req;
      cpu_we[i] = req;
      cpu_addr[i] = addr;
      cpu_wdata[i] = data;
      cpu_wstrb[i] = req ? 4'hF : 4'h0;
    end
  endtask
  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    sb_q.push_back('{we: 1'b1, addr: addr, wdata: data, wstrb: 4'hF});
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_req"}, 64'(voted_req), 64'd0);
    check({tag, "_addr"}, 64'(voted_addr), 64'd0);
    check({tag, "_wdata"}, 64'(voted_wdata), 64'd0);
    check({tag, "_ack"}, 64'(cpu_ack), 64'd0);
    check({tag, "_inv"}, 64'(bus_invalid), 64'd0);
    check({tag, "_back"}, 64'(back_online), 64'd0);
    check({tag, "_nomaj"}, 64'(no_majority), 64'd0);
  endtask
  always @(negedge clk)
    if (!areset && voted_req && ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else begin
        sb_e = sb_q.pop_front();
        check("sb_we", 64'(voted_we), 64'(sb_e.we));
        check("sb_addr", 64'(voted_addr), 64'(sb_e.addr));
        check("sb_wdata", 64'(voted_wdata), 64'(sb_e.wdata));
        check("sb_wstrb", 64'(voted_wstrb), 64'(sb_e.wstrb));
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    set_all(1'b0, 32'h0, 32'h0);
    repeat (2) tick;
    check_reset("rst");
    areset = 1'b0;
    set_all(1'b1, A0, D0); push(A0, D0); tick;
    check("t1_req", 64'(voted_req), 64'd1);
    check("t1_ack", 64'(cpu_ack), 64'h7);
    check("t1_inv", 64'(bus_invalid), 64'd0);
    set_all(1'b0, 32'h0, 32'h0); tick;
    check("t1_idle", 64'(voted_req), 64'd0);
    set_all(1'b1, A0, D0); cpu_addr[1] = A1; push(A0, D0); tick;
    set_all(1'b1, A0, D0); push(A0, D0); tick;
    check("t2_single", 64'(bus_invalid), 64'd0);
    set_all(1'b1, A0, D0); cpu_addr[1] = A1; push(A0, D0); tick;
    check("t2_first", 64'(bus_invalid), 64'd0);
    set_all(1'b1, A0, D0); cpu_addr[1] = A1; push(A0, D0); tick;
    check("t2_fault", 64'(bus_invalid), 64'h2);
    check("t2_ack", 64'(cpu_ack), 64'h5);
    set_all(1'b0, 32'h0, 32'h0); repeat (3) tick;
    check("t2_sticky", 64'(bus_invalid), 64'h2);
    cpu_rst = 3'b010; tick;
    check("t3_excl", 64'(bus_invalid), 64'd0);
    repeat (2) tick;
    cpu_rst = 3'b000; tick;
    for (int k = 0; k < 13; k++) begin
      set_all(1'b1, A0, D0);
      if (k == 4) cpu_addr[1] = A1;
      push(A0, D0);
      tick;
      if (k == 3) check("t3_resync_ack", 64'(cpu_ack), 64'h7);
      if (k == 4) check("t3_no_fault", 64'(bus_invalid), 64'd0);
      if (k == 11) check("t3_restart", 64'(back_online), 64'd0);
      if (k == 12) check("t3_back", 64'(back_online), 64'd1);
    end
    set_all(1'b0, 32'h0, 32'h0); tick;
    check("t3_hold", 64'(back_online), 64'd1);
    ack_bo = 1'b1; tick;
    check("t3_clear", 64'(back_online), 64'd0);
    ack_bo = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_all(1'b1, A0, D0); cpu_addr[1] = A1; push(A0, D0); tick;
    end
    check("t4_cpu1", 64'(bus_invalid), 64'h2);
    set_all(1'b0, 32'h0, 32'h0); repeat (2) tick;
    set_all(1'b1, A0, D0); cpu_wdata[2] = D1; tick;
    check("t4_nomaj", 64'(no_majority), 64'd1);
    check("t4_noreq", 64'(voted_req), 64'd0);
    check("t4_inv1", 64'(bus_invalid), 64'h2);
    tick;
    check("t4_all", 64'(bus_invalid), 64'h7);
    set_all(1'b0, 32'h0, 32'h0); tick;
    areset = 1'b1; tick;
    check_reset("grst");
    areset = 1'b0;
    ready = 1'b0; set_all(1'b1, A2, D2); push(A2, D2); tick;
    for (int k = 0; k < 5; k++) begin
      check("t5_req", 64'(voted_req), 64'd1);
      check("t5_addr", 64'(voted_addr), 64'(A2));
      check("t5_wdata", 64'(voted_wdata), 64'(D2));
      check("t5_ack", 64'(cpu_ack), 64'd0);
      tick;
    end
    check("t5_inv", 64'(bus_invalid), 64'd0);
    ready = 1'b1; set_all(1'b0, 32'h0, 32'h0); #1;
    check("t5_accept_ack", 64'(cpu_ack), 64'h7);
    tick;
    check("t5_done", 64'(voted_req), 64'd0);
    check("t5_done_ack", 64'(cpu_ack), 64'd0);
    cpu_rst = 3'b100; tick;
    cpu_rst = 3'b000; tick;
    ready = 1'b0; set_all(1'b1, A3, D3); repeat (2) tick;
    check("t6_stall", 64'(voted_req), 64'd1);
    areset = 1'b1; tick;
    check_reset("t6");
    areset = 1'b0; ready = 1'b1;
    set_all(1'b1, A5, D0); cpu_addr[0] = A4; push(A5, D0); tick;
    check("t6_nomaj", 64'(no_majority), 64'd0);
    check("t6_ack", 64'(cpu_ack), 64'h7);
    set_all(1'b0, 32'h0, 32'h0); repeat (2) tick;
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
